seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 44 ++++
 rtl/seq_alu_muldiv.sv | 127 ++++++++++++
 rtl/seq_alu.sv | 156 +++++++++++++++
 tb/tb_seq_alu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encodings, shift-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_alu_pkg;

  // Opcode encoding (12-15 are reserved and behave as a zero-result CALC op)
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SLLV  = 4'd6;
  localparam logic [3:0] OP_SRAV  = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;

  // Top-level control FSM
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Iterative multiply/divide engine sequencing
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Shift-amount width: log2 of the (power-of-two) operand width
  function automatic int calc_shw(input int width);
    int n;
    n = 0;
    while ((1 << n) < width) n++;
    return n;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with sign fix-up.
// Latency: WIDTH run cycles + 1 fix-up cycle (done pulses in fix-up); divide by zero goes straight to fix-up.
// Backpressure: none; start is only honoured while idle, results valid only while done=1.
// Ports: clk, reset (async high); start/is_div/is_signed + src_a/src_b launch an op;
//        done (1-cycle), hi, lo, div_zero are combinational from the fix-up state.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int SHW   = calc_shw(WIDTH);
  localparam int CNT_W = SHW + 1;

  md_state_t        r_state;
  logic [WIDTH-1:0] r_hi;     // mul: running upper product; div: partial remainder
  logic [WIDTH-1:0] r_lo;     // mul: multiplier shifting out; div: dividend in / quotient out
  logic [WIDTH-1:0] r_opb;    // |src_b|: multiplicand or divisor
  logic [WIDTH-1:0] r_a;      // original src_a, returned as remainder on divide-by-zero
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic             r_neg_main; // product / quotient sign
  logic             r_neg_rem;  // remainder follows the dividend sign
  logic             r_dz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_dz;

  assign w_a_neg = is_signed & src_a[WIDTH-1];
  assign w_b_neg = is_signed & src_b[WIDTH-1];
  // Most-negative stays most-negative, which is its correct unsigned magnitude.
  assign w_mag_a = w_a_neg ? -src_a : src_a;
  assign w_mag_b = w_b_neg ? -src_b : src_b;
  assign w_dz    = is_div & (src_b == '0);

  // Multiply step: conditionally add multiplicand to the upper half, shift right
  logic [WIDTH:0]   w_sum;
  // Divide step: shift next dividend bit into the remainder, subtract if it fits
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_sub;
  logic             w_ge;

  assign w_sum     = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : '0)};
  assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_opb};
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= MD_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opb      <= '0;
      r_a        <= '0;
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_hi       <= '0;
            r_lo       <= w_mag_a;
            r_opb      <= w_mag_b;
            r_a        <= src_a;
            r_cnt      <= '0;
            r_div      <= is_div;
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_dz       <= w_dz;
            r_state    <= w_dz ? MD_FIX : MD_RUN;
          end
        end
        MD_RUN: begin
          if (r_div) begin
            r_hi <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= MD_FIX;
        end
        MD_FIX:  r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // Sign fix-up on the magnitude result, presented during the fix-up cycle
  logic [2*WIDTH-1:0] w_prod;

  always_comb begin
    w_prod   = r_neg_main ? -{r_hi, r_lo} : {r_hi, r_lo};
    done     = (r_state == MD_FIX);
    div_zero = 1'b0;
    hi       = w_prod[2*WIDTH-1:WIDTH];
    lo       = w_prod[WIDTH-1:0];
    if (r_dz) begin
      div_zero = 1'b1;
      hi       = r_a;
      lo       = '1;
    end else if (r_div) begin
      hi = r_neg_rem  ? -r_hi : r_hi;
      lo = r_neg_main ? -r_lo : r_lo;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops via CALC, multiply/divide via the iterative engine.
// Latency: start-to-done 2 cycles for ops 0-7/12-15 and divide-by-zero, WIDTH+2 for MUL/DIV.
// Backpressure: busy=1 from accepted start through the done cycle; start while busy is dropped.
// Ports: clk, reset (async high); start, alu_op, src_a, src_b, shamt in;
//        busy, done (1-cycle pulse), result, hi, lo, zero, div_zero out (registered, held to next done).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = calc_shw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             div_zero
);

  state_t           r_state;
  state_t           w_next;

  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SHW-1:0]   r_shamt;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_zero;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_is_md;
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic             w_md_dz;
  logic             w_md_fin;
  logic [WIDTH-1:0] w_calc;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_is_md    = (alu_op[3:2] == 2'b10);   // opcodes 8..11
  assign w_md_start = w_accept && w_is_md;
  assign w_md_fin   = ((r_state == ST_MUL) || (r_state == ST_DIV)) && w_md_done;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_is_md) w_next = alu_op[1] ? ST_DIV : ST_MUL;
          else         w_next = ST_CALC;
        end
      end
      ST_CALC: w_next = ST_DONE;
      ST_MUL:  if (w_md_done) w_next = ST_DONE;
      ST_DIV:  if (w_md_done) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode; busy covers the done cycle so a start there is ignored
  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  // Single-cycle operations on the latched operands
  always_comb begin
    w_calc = '0;
    case (r_op)
      OP_ADD:  w_calc = r_a + r_b;
      OP_SUB:  w_calc = r_a - r_b;
      OP_AND:  w_calc = r_a & r_b;
      OP_OR:   w_calc = r_a | r_b;
      OP_SLT:  w_calc = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_SLL:  w_calc = r_b << r_shamt;
      OP_SLLV: w_calc = r_a << r_b[SHW-1:0];
      OP_SRAV: w_calc = $signed(r_b) >>> r_a[SHW-1:0];
      default: w_calc = '0;
    endcase
  end

  // Operand latch and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_shamt    <= '0;
      r_result   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_zero     <= 1'b1;
      r_div_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= alu_op;
        r_a     <= src_a;
        r_b     <= src_b;
        r_shamt <= shamt;
      end
      if (r_state == ST_CALC) begin
        r_result   <= w_calc;
        r_zero     <= (w_calc == '0);
        r_div_zero <= 1'b0;
      end else if (w_md_fin) begin
        r_result   <= w_md_lo;
        r_hi       <= w_md_hi;
        r_lo       <= w_md_lo;
        r_zero     <= (w_md_lo == '0);
        r_div_zero <= w_md_dz;
      end
    end
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (w_md_start),
    .is_div    (alu_op[1]),
    .is_signed (~alu_op[0]),
    .src_a     (src_a),
    .src_b     (src_b),
    .done      (w_md_done),
    .hi        (w_md_hi),
    .lo        (w_md_lo),
    .div_zero  (w_md_dz)
  );

  assign result   = r_result;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign zero     = r_zero;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vector table, randomized ops
// against an arithmetic reference model, and reset/ignored-start corner sequences.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] src_a, src_b;
  logic [4:0]  shamt;
  logic        busy, done, zero, div_zero;
  logic [31:0] result, hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  // Model view of the hi/lo registers, which persist across CALC ops
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  seq_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .alu_op   (alu_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .hi       (hi),
    .lo       (lo),
    .zero     (zero),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, updates m_hi/m_lo for mul/div ops
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output logic dz,
                       output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sb  = $signed(b);
    dz  = 1'b0;
    lat = 2;
    res = '0;
    case (op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd5:  res = b << sh;
      4'd6:  res = a << b[4:0];
      4'd7:  res = 32'($signed(b) >>> a[4:0]);
      4'd8, 4'd9: begin
        if (op == 4'd8) p = 64'(sa * sb);
        else            p = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        res  = m_lo;
        lat  = 34;
      end
      4'd10, 4'd11: begin
        if (b == 32'd0) begin
          dz   = 1'b1;
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          lat = 34;
          if (op == 4'd10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
          end
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        res = m_lo;
      end
      default: res = '0;
    endcase
  endtask

  // Launch one op at a negedge and check the completion; optionally pulse a
  // stray start (ADD with junk operands) at cycle inject_at while busy.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] e_res, input logic [31:0] e_hi,
                       input logic [31:0] e_lo, input logic e_dz, input int e_lat,
                       input int inject_at, input string tag);
    int lat;
    alu_op = op;
    src_a  = a;
    src_b  = b;
    shamt  = sh;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    chk({tag, " busy_c1"}, busy, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      if (c == inject_at) begin
        start  = 1'b1;
        alu_op = OP_ADD;
        src_a  = $urandom;
        src_b  = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " latency"}, 64'(lat), 64'(e_lat));
    chk({tag, " result"}, result, e_res);
    chk({tag, " hi"}, hi, e_hi);
    chk({tag, " lo"}, lo, e_lo);
    chk({tag, " zero"}, zero, (e_res == 32'd0));
    chk({tag, " div_zero"}, div_zero, e_dz);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " busy_after"}, busy, 1'b0);
  endtask

  // Model-driven wrapper used by random and corner sequences
  task automatic run_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input int inject_at, input string tag);
    logic [31:0] e_res;
    logic        e_dz;
    int          e_lat;
    model(op, a, b, sh, e_res, e_dz, e_lat);
    do_op(op, a, b, sh, e_res, m_hi, m_lo, e_dz, e_lat, inject_at, tag);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] res, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    int          ndone;

    // Directed vectors, applied in order (hi/lo carry over between rows)
    tbl[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 32'h0,          32'h0,          1'b0, 2};
    tbl[1]  = '{4'd4,  32'hFFFF_FFFB, 32'h0000_0003, 5'd0,  32'h0000_0001, 32'h0,          32'h0,          1'b0, 2};
    tbl[2]  = '{4'd7,  32'h0000_0004, 32'h8000_0000, 5'd0,  32'hF800_0000, 32'h0,          32'h0,          1'b0, 2};
    tbl[3]  = '{4'd8,  32'hFFFF_FFFD, 32'h0000_0007, 5'd0,  32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    tbl[4]  = '{4'd1,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 2};
    tbl[5]  = '{4'd10, 32'hFFFF_FFF9, 32'h0000_0002, 5'd0,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    tbl[6]  = '{4'd11, 32'h0000_0007, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 2};
    tbl[7]  = '{4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 2};
    tbl[8]  = '{4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    tbl[9]  = '{4'd13, 32'h0000_0005, 32'h0000_0006, 5'd3,  32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 2};
    tbl[10] = '{4'd5,  32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 2};
    tbl[11] = '{4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    tbl[12] = '{4'd6,  32'h0000_0003, 32'h0000_0021, 5'd0,  32'h0000_0006, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2};
    tbl[13] = '{4'd3,  32'h0000_0000, 32'h0000_0000, 5'd0,  32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2};

    reset  = 1'b1;
    start  = 1'b0;
    alu_op = '0;
    src_a  = '0;
    src_b  = '0;
    shamt  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst result", result, 32'h0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst zero", zero, 1'b1);
    chk("rst div_zero", div_zero, 1'b0);

    // Directed table; first op launches on the very first edge after reset
    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].res, tbl[i].hi, tbl[i].lo,
            tbl[i].dz, tbl[i].lat, 0, $sformatf("vec%0d", i));
      m_hi = tbl[i].hi;
      m_lo = tbl[i].lo;
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'($urandom_range(0, 100)); r_b = 32'($urandom_range(1, 9)); end
        2: r_b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_model(r_op, r_a, r_b, 5'($urandom), 0, $sformatf("rnd%0d op%0d", i, r_op));
    end

    // Stray start during a DIV must not disturb it
    run_model(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd0, 5, "mid_start");
    // Start during the done cycle must be ignored
    run_model(OP_ADD, 32'd40, 32'd2, 5'd0, 2, "done_start");

    // Reset at iteration 10 of MULTU: abort, no done, reset values
    alu_op = OP_MULTU;
    src_a  = 32'h1234_5678;
    src_b  = 32'h9ABC_DEF1;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort result", result, 32'h0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    chk("abort zero", zero, 1'b1);
    chk("abort div_zero", div_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort no_done", 64'(ndone), 64'd0);
    chk("abort hi_held", hi, 32'h0);
    m_hi = '0;
    m_lo = '0;
    run_model(OP_ADD, 32'd3, 32'd4, 5'd0, 0, "post_reset_add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
